pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
Reset and lock supervisor for the Gowin rPLL clock generator. Runs on the 25 MHz board reference clock. Drives the PLL's active-high reset input and consumes the PLL's lock output. Releases the system reset only after lock has been stable, retries acquisition with a timeout, and re-sequences on lock loss. sys_rst_n is re-synchronised into the PLL output domain by the consumer.

Parameters:
RST_CYCLES, 16, cycles pll_reset is held high per acquisition attempt (>=1)
LOCK_TIMEOUT, 25000, cycles to wait for lock after pll_reset release (1 ms at 25 MHz)
STABLE_CYCLES, 256, consecutive cycles lock must stay high before release
MAX_RETRIES, 3, timeouts tolerated before FAIL (total attempts = MAX_RETRIES+1, max 15)

Ports:
clkin  input  1  25 MHz reference clock; all logic on rising edge
resetn  input  1  asynchronous active-low reset
pll_lock  input  1  PLL LOCK, asynchronous to clkin
restart  input  1  synchronous one-cycle pulse: abort and re-acquire from HOLD
pll_reset  output  1  to PLL RESET, active high
sys_rst_n  output  1  system reset, active low, high only in RUN
ready  output  1  high only in RUN
fail  output  1  high only in FAIL
retry_cnt  output  4  timeouts in the current acquisition
loss_cnt  output  8  lock losses seen in RUN, saturating

Behaviour:
- Reset (resetn low, async): state=HOLD, pll_reset=1, sys_rst_n=0, ready=0, fail=0, retry_cnt=0, loss_cnt=0, cycle counter=0, sync flops=0.
- pll_lock passes through 2-FF synchroniser -> lock_s. lock_s lags pll_lock by 2 edges.
- All outputs are registered decodes of the next state, so they change on the same edge as the state.
- Single cycle counter, cleared on every state change. Width = clog2 of max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
- HOLD: pll_reset=1. When counter==RST_CYCLES-1, go to WAIT. pll_reset is therefore high exactly RST_CYCLES cycles.
- WAIT: pll_reset=0.
  - If lock_s=1, go to STABLE.
  - Else, if counter==LOCK_TIMEOUT-1: go to FAIL if retry_cnt==MAX_RETRIES; otherwise retry_cnt+1 and go to HOLD.
  - If lock_s rises on the timeout cycle, lock wins.
- STABLE: pll_reset=0.
  - If lock_s=0, go to WAIT (timeout restarts, retry_cnt unchanged).
  - Else, if counter==STABLE_CYCLES-1, go to RUN.
  - Any single-cycle drop restarts qualification.
- RUN: pll_reset=0, sys_rst_n=1, ready=1.
  - If lock_s=0, go to HOLD, loss_cnt+1 (saturate at 255), retry_cnt cleared.
  - sys_rst_n falls on that same edge, 3 edges after the pll_lock fall.
- FAIL: pll_reset=1 (held), fail=1, retry_cnt frozen. Exit only via restart or resetn.
- restart=1 in any state: next state HOLD, counter cleared, retry_cnt cleared, fail cleared, sys_rst_n/ready low on that edge, loss_cnt unchanged.
  - restart has priority over lock and timeout events in the same cycle.
  - restart while already in HOLD restarts the HOLD count.
- resetn asserted mid-operation: all outputs take reset values immediately, without waiting for a clock edge. Deassertion is synchronised externally.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2):
1. Release resetn, raise pll_lock 5 cycles after pll_reset falls -> pll_reset high exactly 4 cycles; ready and sys_rst_n rise on the 11th clkin edge after pll_lock rises; retry_cnt=0.
2. pll_lock held 0 -> three 20-cycle WAIT windows, pll_reset pulses 4 cycles between them, retry_cnt steps 1, 2 -> FAIL with fail=1, retry_cnt=2, pll_reset stuck 1.
3. In STABLE at counter 5, drop pll_lock for 1 cycle -> return to WAIT, ready stays 0, retry_cnt unchanged; ready rises only after a full 8-cycle stable run.
4. In RUN, drop pll_lock -> sys_rst_n and ready low 3 edges later, loss_cnt=1, pll_reset high 4 cycles, re-lock reaches RUN again.
5. In FAIL, pulse restart together with lock_s=1 -> HOLD next edge, fail=0, retry_cnt=0. Assert resetn mid-STABLE -> pll_reset=1, sys_rst_n=0 with no clock edge.
6. 256 lock losses in RUN -> loss_cnt reaches 255 and holds at 255.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// Reset/lock supervisor for an rPLL: pulses the PLL reset, qualifies lock for a stable
// window, releases the system reset, retries on timeout and re-sequences on lock loss.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 25000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] dbg_state
);

  localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          lock_m_q, lock_s_q;
  logic          pll_reset_q, sys_rst_n_q, ready_q, fail_q;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (restart) begin
      state_d = ST_HOLD;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == RST_LAST) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          // A lock arriving on the timeout cycle beats the timeout.
          if (lock_s_q) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              retry_d = retry_q + 4'd1;
              state_d = ST_HOLD;
            end
          end
        end
        ST_STABLE: begin
          if (!lock_s_q) state_d = ST_WAIT;
          else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!lock_s_q) begin
            state_d = ST_HOLD;
            retry_d = '0;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_HOLD;
      endcase
    end
    // A restart in HOLD keeps the state but must still restart the count.
    cnt_d = (restart || (state_d != state_q)) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      lock_m_q    <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      lock_m_q    <= pll_lock;
      lock_s_q    <= lock_m_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= (state_d == ST_HOLD) || (state_d == ST_FAIL);
      sys_rst_n_q <= (state_d == ST_RUN);
      ready_q     <= (state_d == ST_RUN);
      fail_q      <= (state_d == ST_FAIL);
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed + randomized bench for pll_lock_sequencer; acquisition latency and counters are
// predicted arithmetically from the sequencing rules and compared with immediate assertions.
module tb_pll_lock_sequencer;

  localparam int T_RST  = 4;
  localparam int T_TO   = 20;
  localparam int T_ST   = 8;
  localparam int T_SYNC = 2;

  localparam int S_RST = 0;
  localparam int S_SYS = 1;
  localparam int S_RDY = 2;

  logic       clkin;
  logic       resetn;
  logic       pll_lock;
  logic       restart;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  int model_loss = 0;
  logic [31:0] exp_q[$];

  pll_lock_sequencer #(
    .RST_CYCLES   (T_RST),
    .LOCK_TIMEOUT (T_TO),
    .STABLE_CYCLES(T_ST),
    .MAX_RETRIES  (2)
  ) dut (
    .clkin    (clkin),
    .resetn   (resetn),
    .pll_lock (pll_lock),
    .restart  (restart),
    .pll_reset(pll_reset),
    .sys_rst_n(sys_rst_n),
    .ready    (ready),
    .fail     (fail),
    .retry_cnt(retry_cnt),
    .loss_cnt (loss_cnt),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      S_RST:   return pll_reset;
      S_SYS:   return sys_rst_n;
      default: return ready;
    endcase
  endfunction

  // Counts negedge samples (starting with the current one) while the signal holds lvl.
  task automatic count_while(input int sel, input logic lvl, input int limit, output int n);
    n = 0;
    while (sig(sel) === lvl && n < limit) begin
      n++;
      @(negedge clkin);
    end
  endtask

  // Lock raised d cycles after pll_reset falls: WAIT sees it SYNC+1 edges later; the
  // timeout is decided on edge T_TO-d. Lock wins ties; otherwise one more HOLD/WAIT pass.
  function automatic int exp_latency(input int d);
    if (T_SYNC + 1 <= T_TO - d) return T_SYNC + 1 + T_ST;
    return (T_TO - d) + T_RST + 1 + T_ST;
  endfunction

  function automatic int exp_retry(input int d);
    return (T_SYNC + 1 <= T_TO - d) ? 0 : 1;
  endfunction

  // Entered at the negedge where pll_reset has just fallen, with pll_lock low.
  task automatic acquire(input int d);
    int n;
    exp_q.push_back(32'(exp_latency(d)));
    exp_q.push_back(32'(exp_retry(d)));
    repeat (d) @(negedge clkin);
    pll_lock = 1'b1;
    count_while(S_RDY, 1'b0, 60, n);
    chk("ready_latency", 32'(n), exp_q.pop_front());
    chk("retry_after_acq", 32'(retry_cnt), exp_q.pop_front());
    chk("sys_rst_n_in_run", 32'(sys_rst_n), 32'd1);
  endtask

  task automatic lose();
    int n;
    pll_lock = 1'b0;
    count_while(S_SYS, 1'b1, 20, n);
    chk("loss_latency", 32'(n), 32'(T_SYNC + 1));
    if (model_loss < 255) model_loss++;
    chk("ready_after_loss", 32'(ready), 32'd0);
    chk("loss_cnt", 32'(loss_cnt), 32'(model_loss));
    chk("retry_after_loss", 32'(retry_cnt), 32'd0);
    count_while(S_RST, 1'b1, 20, n);
    chk("hold_len_loss", 32'(n), 32'(T_RST));
  endtask

  task automatic restart_pulse(input logic lock);
    int n;
    pll_lock = lock;
    restart  = 1'b1;
    @(negedge clkin);
    restart = 1'b0;
    chk("rs_pll_reset", 32'(pll_reset), 32'd1);
    chk("rs_sys_rst_n", 32'(sys_rst_n), 32'd0);
    chk("rs_ready", 32'(ready), 32'd0);
    chk("rs_fail", 32'(fail), 32'd0);
    chk("rs_retry", 32'(retry_cnt), 32'd0);
    chk("rs_loss", 32'(loss_cnt), 32'(model_loss));
    count_while(S_RST, 1'b1, 20, n);
    chk("hold_len_restart", 32'(n), 32'(T_RST));
  endtask

  initial begin
    int n;
    resetn   = 1'b0;
    pll_lock = 1'b0;
    restart  = 1'b0;
    repeat (3) @(negedge clkin);
    chk("reset_pll_reset", 32'(pll_reset), 32'd1);
    chk("reset_sys_rst_n", 32'(sys_rst_n), 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_fail", 32'(fail), 32'd0);
    chk("reset_retry", 32'(retry_cnt), 32'd0);
    chk("reset_loss", 32'(loss_cnt), 32'd0);

    // first acquisition, lock 5 cycles after pll_reset falls
    resetn = 1'b1;
    count_while(S_RST, 1'b1, 20, n);
    chk("hold_len_first", 32'(n), 32'(T_RST));
    acquire(5);

    // lock loss in RUN, then re-lock
    lose();
    acquire(int'($urandom_range(0, 21)));

    // single-cycle lock dip late in STABLE restarts qualification
    restart_pulse(1'b1);
    repeat (4) @(negedge clkin);
    pll_lock = 1'b0;
    @(negedge clkin);
    chk("dip_ready_low", 32'(ready), 32'd0);
    pll_lock = 1'b1;
    count_while(S_RDY, 1'b0, 40, n);
    chk("dip_latency", 32'(n), 32'(T_SYNC + 1 + T_ST));
    chk("dip_retry", 32'(retry_cnt), 32'd0);

    // no lock at all: three timeout windows then FAIL
    restart_pulse(1'b0);
    for (int a = 0; a < 3; a++) begin
      chk("retry_step", 32'(retry_cnt), 32'(a));
      count_while(S_RST, 1'b0, 40, n);
      chk("wait_window", 32'(n), 32'(T_TO));
      if (a < 2) begin
        count_while(S_RST, 1'b1, 40, n);
        chk("hold_between", 32'(n), 32'(T_RST));
      end
    end
    chk("fail_flag", 32'(fail), 32'd1);
    chk("fail_retry", 32'(retry_cnt), 32'd2);
    count_while(S_RST, 1'b1, 30, n);
    chk("fail_reset_held", 32'(n), 32'd30);

    // lock arriving in FAIL is ignored; restart wins over it
    pll_lock = 1'b1;
    repeat (3) @(negedge clkin);
    chk("fail_ignores_lock", 32'(fail), 32'd1);
    restart_pulse(1'b1);

    // async reset mid-STABLE
    repeat (3) @(negedge clkin);
    #2 resetn = 1'b0;
    #1;
    chk("async_pll_reset", 32'(pll_reset), 32'd1);
    chk("async_sys_rst_n", 32'(sys_rst_n), 32'd0);
    chk("async_ready", 32'(ready), 32'd0);
    chk("async_loss", 32'(loss_cnt), 32'd0);
    model_loss = 0;
    @(negedge clkin);
    resetn = 1'b1;
    count_while(S_RST, 1'b1, 20, n);
    chk("hold_len_post_reset", 32'(n), 32'(T_RST));
    count_while(S_RDY, 1'b0, 40, n);
    chk("post_reset_latency", 32'(n), 32'(1 + T_ST));

    // restart while in HOLD restarts the HOLD count
    pll_lock = 1'b0;
    restart  = 1'b1;
    @(negedge clkin);
    restart = 1'b0;
    repeat (2) @(negedge clkin);
    restart_pulse(1'b0);

    // randomized acquisition timing, including lock near and past the timeout
    for (int k = 0; k < 6; k++) begin
      acquire(int'($urandom_range(0, 21)));
      restart_pulse(1'b0);
    end
    acquire(int'($urandom_range(0, 21)));

    // loss counter saturation
    for (int k = 0; k < 256; k++) begin
      lose();
      acquire(int'($urandom_range(0, 21)));
    end
    chk("loss_saturated", 32'(loss_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
